// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared FSM encodings and iteration constants for the sequential multiplier
package mul_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
    localparam int MUL_ITER = 32;
    localparam int CNT_W = 5;
endpackage

// File: rtl/yAdder.sv
// yAdder: 32-bit ripple-style adder with carry in and carry out
module yAdder (
    output logic [31:0] z,
    output logic        cout,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin
);
    assign {cout, z} = {1'b0, a} + {1'b0, b} + {32'b0, cin};
endmodule

// File: rtl/mul_seq.sv
// mul_seq: 32x32 unsigned shift-add multiplier, one conditional add-and-shift per clock
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);
    state_t             state, next;
    logic [W-1:0]       mcand, acc_hi, acc_lo, addend, sum;
    logic [CNT_W-1:0]   cnt;
    logic               cout, last;
    logic [2*W-1:0]     shifted;

    assign last    = cnt == CNT_W'(MUL_ITER - 1);
    // operand is zeroed rather than bypassing the adder, keeping a single add path
    assign addend  = acc_lo[0] ? mcand : '0;
    assign shifted = {cout, sum, acc_lo[W-1:1]};
    assign busy    = state != IDLE;
    assign done    = state == DONE;

    yAdder u_add (
        .z    (sum),
        .cout (cout),
        .a    (acc_hi),
        .b    (addend),
        .cin  (1'b0)
    );

    always_comb begin
        next = IDLE;
        next = (state == IDLE) ? (start ? RUN : IDLE) :
               (state == RUN)  ? (last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (state == IDLE && start) begin
            mcand  <= a;
            acc_lo <= b;
            acc_hi <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            {acc_hi, acc_lo} <= shifted;
            cnt              <= cnt + 1'b1;
            if (last)
                product <= shifted;
        end
    end
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: randomized self-checking bench for mul_seq against plain 64-bit multiplication
module tb_mul_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [63:0] product;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_product = '0;

    mul_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    // Called on a negedge with the DUT idle; returns on the first idle negedge after done.
    task automatic do_mul(input string name, input logic [31:0] x, input logic [31:0] y,
                          input bit poke_start);
        logic [63:0] exp_p;
        int          lat, busy_n;
        exp_p = {32'b0, x} * {32'b0, y};
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_accept got=%b want=1", name, busy);
        end
        lat = 0;
        busy_n = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (busy === 1'b1) busy_n++;
            if (lat == 10) begin
                checks++;
                if (product !== last_product) begin
                    errors++;
                    $display("FAIL %s product_during_run got=%h want=%h", name, product, last_product);
                end
            end
            if (poke_start && lat == 5) begin
                start = 1'b1;
                a = 32'd2;
                b = 32'd2;
            end
            if (poke_start && lat == 8) start = 1'b0;
            lat++;
            @(negedge clk);
        end
        if (busy === 1'b1) busy_n++;
        checks++;
        if (lat != 32) begin
            errors++;
            $display("FAIL %s done_latency got=%0d want=32", name, lat);
        end
        checks++;
        if (busy_n != 33) begin
            errors++;
            $display("FAIL %s busy_cycles got=%0d want=33", name, busy_n);
        end
        checks++;
        if (product !== exp_p) begin
            errors++;
            $display("FAIL %s product got=%h want=%h", name, product, exp_p);
        end
        last_product = exp_p;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_idle got busy=%b done=%b want 0/0", name, busy, done);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
            errors++;
            $display("FAIL reset got busy=%b done=%b product=%h want 0/0/0", busy, done, product);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_mul("small_3x5", 32'd3, 32'd5, 1'b0);
    endtask

    task automatic test_max();
        do_mul("max_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        checks++;
        if (last_product !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL max_const model=%h want=%h", last_product, 64'hFFFF_FFFE_0000_0001);
        end
    endtask

    task automatic test_zero();
        do_mul("b_zero", 32'h1234_5678, 32'd0, 1'b0);
        do_mul("a_zero", 32'd0, 32'h8765_4321, 1'b0);
    endtask

    task automatic test_ignore_start();
        do_mul("ignore_start_7x9", 32'd7, 32'd9, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL ignore_start_extra got busy=%b done=%b want 0/0", busy, done);
            end
        end
    endtask

    task automatic test_abort();
        a = 32'd100;
        b = 32'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
            errors++;
            $display("FAIL abort got busy=%b done=%b product=%h want 0/0/0", busy, done, product);
        end
        last_product = '0;
        a = 32'd6;
        b = 32'd7;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_mul("after_abort_6x7", 32'd6, 32'd7, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        for (int i = 0; i < 10; i++) begin
            x = $urandom;
            y = $urandom;
            do_mul($sformatf("rand%0d", i), x, y, 1'b0);
            $display("case %0d ok=%0b product=%h expect=%h", i,
                     product === {32'b0, x} * {32'b0, y}, product, {32'b0, x} * {32'b0, y});
        end
    endtask

    task automatic test_back_to_back();
        do_mul("b2b_first", 32'hDEAD_BEEF, 32'h0000_0003, 1'b0);
        do_mul("b2b_second", 32'h8000_0001, 32'h8000_0001, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_ignore_start();
        test_abort();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
